// File: rtl/can_pkg.sv
// Shared CAN 2.0A definitions: FSM states, field lengths, error codes and the CRC-15 step.
package can_pkg;

  localparam int unsigned ID_LEN   = 11;
  localparam int unsigned DLC_LEN  = 4;
  localparam int unsigned CTRL_LEN = 2 + DLC_LEN;  // IDE, r0, DLC
  localparam int unsigned CRC_LEN  = 15;
  localparam int unsigned EOF_LEN  = 7;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned CNT_W    = 7;
  localparam int unsigned IFS_PRESET = 7;          // idle count already earned by EOF

  localparam logic [CRC_LEN-1:0] CRC_POLY = 15'h4599;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_STUFF = 3'd1;
  localparam logic [2:0] ERR_FORM  = 3'd2;
  localparam logic [2:0] ERR_CRC   = 3'd3;
  localparam logic [2:0] ERR_IDE   = 3'd4;

  typedef enum logic [3:0] {
    ST_WAIT_IDLE = 4'd0,
    ST_IDLE      = 4'd1,
    ST_ARB       = 4'd2,
    ST_CTRL      = 4'd3,
    ST_DATA      = 4'd4,
    ST_CRC       = 4'd5,
    ST_CRC_DEL   = 4'd6,
    ST_ACK_SLOT  = 4'd7,
    ST_ACK_DEL   = 4'd8,
    ST_EOF       = 4'd9
  } state_e;

  // One serial CRC-15 step, MSB-first.
  function automatic logic [CRC_LEN-1:0] crc15_step(input logic [CRC_LEN-1:0] crc,
                                                    input logic              b);
    logic                fb;
    logic [CRC_LEN-1:0]  nxt;
    fb  = b ^ crc[CRC_LEN-1];
    nxt = {crc[CRC_LEN-2:0], 1'b0};
    if (fb) nxt = nxt ^ CRC_POLY;
    return nxt;
  endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CRC-15 (CAN polynomial), one bit per enabled cycle; clear has priority.
module can_crc15
  import can_pkg::*;
(
  input  logic               clk,
  input  logic               clear,
  input  logic               enable,
  input  logic               bit_in,
  output logic [CRC_LEN-1:0] crc
);

  logic [CRC_LEN-1:0] crc_q, crc_d;

  // Next CRC value.
  always_comb begin
    crc_d = crc_q;
    if (clear)       crc_d = '0;
    else if (enable) crc_d = crc15_step(crc_q, bit_in);
  end

  // CRC register.
  always_ff @(posedge clk) begin
    crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/can_frame_receiver.sv
// CAN 2.0A standard-frame receiver: destuffing, field parsing, CRC check, ACK drive.
module can_frame_receiver
  import can_pkg::*;
#(
  parameter int unsigned IDLE_BITS = 11,
  parameter int unsigned MAX_BYTES = 8
) (
  input  logic                can_clk,
  input  logic                reset,
  input  logic                rx_bit,
  output logic                ack_out,
  output logic                rx_valid,
  output logic [ID_LEN-1:0]   rx_id,
  output logic                rx_rtr,
  output logic [DLC_LEN-1:0]  rx_dlc,
  output logic [DATA_W-1:0]   rx_data,
  output logic                rx_error,
  output logic [2:0]          err_code,
  output logic                busy
);

  localparam logic [DLC_LEN-1:0] MAX_DLC = DLC_LEN'(MAX_BYTES);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [2:0]           run_cnt_q, run_cnt_d;
  logic                 run_val_q, run_val_d;
  logic [ID_LEN-1:0]    id_q, id_d;
  logic                 rtr_q, rtr_d;
  logic [DLC_LEN-1:0]   dlc_q, dlc_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [CRC_LEN-1:0]   crc_rx_q, crc_rx_d;
  logic                 crc_ok_q, crc_ok_d;
  logic                 ack_q, ack_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [ID_LEN-1:0]    rx_id_q, rx_id_d;
  logic                 rx_rtr_q, rx_rtr_d;
  logic [DLC_LEN-1:0]   rx_dlc_q, rx_dlc_d;
  logic [DATA_W-1:0]    rx_data_q, rx_data_d;
  logic                 rx_error_q, rx_error_d;
  logic [2:0]           err_code_q, err_code_d;
  logic                 busy_q, busy_d;

  logic                 sof_c, in_stuff_c, stuff_bit_c, stuff_err_c, field_bit_c;
  logic [2:0]           err_c;
  logic                 done_c, ack_c;
  logic [DLC_LEN-1:0]   nbytes_c;
  logic [CNT_W-1:0]     data_last_c;
  logic                 crc_clear_c, crc_en_c;
  logic [CRC_LEN-1:0]   crc_val;

  can_crc15 u_crc (
    .clk    (can_clk),
    .clear  (crc_clear_c),
    .enable (crc_en_c),
    .bit_in (rx_bit),
    .crc    (crc_val)
  );

  // Destuffing: classify the sampled bit and track the run of equal destuffed bits.
  always_comb begin
    sof_c       = (state_q == ST_IDLE) && !rx_bit;
    in_stuff_c  = state_q inside {ST_ARB, ST_CTRL, ST_DATA, ST_CRC};
    stuff_bit_c = in_stuff_c && (run_cnt_q == 3'd5);
    stuff_err_c = stuff_bit_c && (rx_bit == run_val_q);
    field_bit_c = in_stuff_c && !stuff_bit_c;
    run_cnt_d   = run_cnt_q;
    run_val_d   = run_val_q;
    if (sof_c || stuff_bit_c || (field_bit_c && rx_bit != run_val_q)) begin
      run_cnt_d = 3'd1;
      run_val_d = rx_bit;
    end else if (field_bit_c) begin
      run_cnt_d = run_cnt_q + 3'd1;
    end
    nbytes_c    = (dlc_q > MAX_DLC) ? MAX_DLC : dlc_q;
    data_last_c = CNT_W'({nbytes_c, 3'b000}) - CNT_W'(1);
    crc_clear_c = reset || (state_q == ST_WAIT_IDLE);
    crc_en_c    = sof_c || (field_bit_c && (state_q inside {ST_ARB, ST_CTRL, ST_DATA}));
  end

  // State register and all flops.
  always_ff @(posedge can_clk) begin
    if (reset) begin
      state_q    <= ST_WAIT_IDLE;
      bit_cnt_q  <= '0;
      run_cnt_q  <= '0;
      run_val_q  <= 1'b0;
      id_q       <= '0;
      rtr_q      <= 1'b0;
      dlc_q      <= '0;
      data_q     <= '0;
      crc_rx_q   <= '0;
      crc_ok_q   <= 1'b0;
      ack_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_id_q    <= '0;
      rx_rtr_q   <= 1'b0;
      rx_dlc_q   <= '0;
      rx_data_q  <= '0;
      rx_error_q <= 1'b0;
      err_code_q <= ERR_NONE;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      run_cnt_q  <= run_cnt_d;
      run_val_q  <= run_val_d;
      id_q       <= id_d;
      rtr_q      <= rtr_d;
      dlc_q      <= dlc_d;
      data_q     <= data_d;
      crc_rx_q   <= crc_rx_d;
      crc_ok_q   <= crc_ok_d;
      ack_q      <= ack_d;
      rx_valid_q <= rx_valid_d;
      rx_id_q    <= rx_id_d;
      rx_rtr_q   <= rx_rtr_d;
      rx_dlc_q   <= rx_dlc_d;
      rx_data_q  <= rx_data_d;
      rx_error_q <= rx_error_d;
      err_code_q <= err_code_d;
      busy_q     <= busy_d;
    end
  end

  // Next state, field bit counter and error detection.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    err_c     = ERR_NONE;
    done_c    = 1'b0;
    ack_c     = 1'b0;
    if (stuff_err_c) begin
      err_c = ERR_STUFF;
    end else begin
      unique case (state_q)
        ST_WAIT_IDLE: begin
          if (!rx_bit) begin
            bit_cnt_d = '0;
          end else if (bit_cnt_q >= CNT_W'(IDLE_BITS - 1)) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (sof_c) begin
            state_d   = ST_ARB;
            bit_cnt_d = '0;
          end
        end
        ST_ARB: begin
          if (field_bit_c) begin
            if (bit_cnt_q == CNT_W'(ID_LEN)) begin
              state_d   = ST_CTRL;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_CTRL: begin
          if (field_bit_c) begin
            if (bit_cnt_q == '0 && rx_bit) begin
              err_c = ERR_IDE;
            end else if (bit_cnt_q == CNT_W'(CTRL_LEN - 1)) begin
              bit_cnt_d = '0;
              state_d   = (!rtr_q && {dlc_q[DLC_LEN-2:0], rx_bit} != '0) ? ST_DATA : ST_CRC;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DATA: begin
          if (field_bit_c) begin
            if (bit_cnt_q == data_last_c) begin
              state_d   = ST_CRC;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_CRC: begin
          if (field_bit_c) begin
            if (bit_cnt_q == CNT_W'(CRC_LEN - 1)) begin
              state_d   = ST_CRC_DEL;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_CRC_DEL: begin
          if (!crc_ok_q)    err_c = ERR_CRC;
          else if (!rx_bit) err_c = ERR_FORM;
          else begin
            ack_c   = 1'b1;
            state_d = ST_ACK_SLOT;
          end
        end
        ST_ACK_SLOT: state_d = ST_ACK_DEL;
        ST_ACK_DEL: begin
          if (!rx_bit) err_c = ERR_FORM;
          else begin
            state_d   = ST_EOF;
            bit_cnt_d = '0;
          end
        end
        ST_EOF: begin
          if (!rx_bit) begin
            err_c = ERR_FORM;
          end else if (bit_cnt_q == CNT_W'(EOF_LEN - 1)) begin
            done_c    = 1'b1;
            state_d   = ST_WAIT_IDLE;
            bit_cnt_d = CNT_W'(IFS_PRESET);
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_WAIT_IDLE;
      endcase
    end
    if (err_c != ERR_NONE) begin
      state_d   = ST_WAIT_IDLE;
      bit_cnt_d = '0;
    end
  end

  // Field capture and registered outputs.
  always_comb begin
    id_d       = id_q;
    rtr_d      = rtr_q;
    dlc_d      = dlc_q;
    data_d     = data_q;
    crc_rx_d   = crc_rx_q;
    crc_ok_d   = crc_ok_q;
    ack_d      = ack_c;
    rx_valid_d = done_c;
    rx_error_d = (err_c != ERR_NONE);
    rx_id_d    = rx_id_q;
    rx_rtr_d   = rx_rtr_q;
    rx_dlc_d   = rx_dlc_q;
    rx_data_d  = rx_data_q;
    err_code_d = err_code_q;
    busy_d     = state_d inside {ST_ARB, ST_CTRL, ST_DATA, ST_CRC, ST_CRC_DEL,
                                 ST_ACK_SLOT, ST_ACK_DEL, ST_EOF};
    if (sof_c) begin
      id_d   = '0;
      rtr_d  = 1'b0;
      dlc_d  = '0;
      data_d = '0;
    end
    if (field_bit_c) begin
      unique case (state_q)
        ST_ARB: begin
          if (bit_cnt_q < CNT_W'(ID_LEN)) id_d = {id_q[ID_LEN-2:0], rx_bit};
          else                            rtr_d = rx_bit;
        end
        ST_CTRL: begin
          if (bit_cnt_q >= CNT_W'(2)) dlc_d = {dlc_q[DLC_LEN-2:0], rx_bit};
        end
        ST_DATA: data_d[~bit_cnt_q[5:0]] = rx_bit;
        ST_CRC: begin
          crc_rx_d = {crc_rx_q[CRC_LEN-2:0], rx_bit};
          if (bit_cnt_q == CNT_W'(CRC_LEN - 1)) begin
            crc_ok_d = ({crc_rx_q[CRC_LEN-2:0], rx_bit} == crc_val);
          end
        end
        default: ;
      endcase
    end
    if (err_c != ERR_NONE) begin
      err_code_d = err_c;
      ack_d      = 1'b0;
    end
    if (done_c) begin
      rx_id_d    = id_q;
      rx_rtr_d   = rtr_q;
      rx_dlc_d   = dlc_q;
      rx_data_d  = data_q;
      err_code_d = ERR_NONE;
    end
  end

  assign ack_out  = ack_q;
  assign rx_valid = rx_valid_q;
  assign rx_id    = rx_id_q;
  assign rx_rtr   = rx_rtr_q;
  assign rx_dlc   = rx_dlc_q;
  assign rx_data  = rx_data_q;
  assign rx_error = rx_error_q;
  assign err_code = err_code_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_can_frame_receiver.sv
// Directed frame-level bench for can_frame_receiver with its own stuffing/CRC frame builder.
module tb_can_frame_receiver;

  localparam int F_NONE  = 0;
  localparam int F_STUFF = 1;
  localparam int F_CRC   = 2;
  localparam int F_EOF4  = 3;
  localparam int F_IDE   = 4;

  typedef struct {
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    int          fault;
    logic        exp_valid;
    logic        exp_ack;
    logic [2:0]  exp_err;
    logic [63:0] exp_data;
  } vec_t;

  logic        can_clk = 1'b0;
  logic        reset;
  logic        rx_bit;
  logic        ack_out, rx_valid, rx_rtr, rx_error, busy;
  logic [10:0] rx_id;
  logic [3:0]  rx_dlc;
  logic [63:0] rx_data;
  logic [2:0]  err_code;

  can_frame_receiver dut (
    .can_clk  (can_clk),
    .reset    (reset),
    .rx_bit   (rx_bit),
    .ack_out  (ack_out),
    .rx_valid (rx_valid),
    .rx_id    (rx_id),
    .rx_rtr   (rx_rtr),
    .rx_dlc   (rx_dlc),
    .rx_data  (rx_data),
    .rx_error (rx_error),
    .err_code (err_code),
    .busy     (busy)
  );

  always #5 can_clk = ~can_clk;

  int   errors = 0;
  int   checks = 0;
  int   cur_frame = -1;

  logic stream [0:255];
  int   slen, crc_del_idx, fault_idx, data_idx;

  int   valid_cnt, valid_idx, err_cnt, err_idx, ack_cnt, ack_idx;
  logic [2:0] err_seen;
  logic busy_sof;

  logic [10:0] last_id;
  logic        last_rtr;
  logic [3:0]  last_dlc;
  logic [63:0] last_data;

  vec_t vecs [0:8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL frame %0d %s: got 0x%0h expected 0x%0h", cur_frame, name, got, exp);
    end
  endtask

  // Build the bus bit sequence for one frame, including ACK/EOF and idle tail.
  task automatic build_frame(input vec_t v);
    logic        u [0:127];
    int          posmap [0:127];
    int          nu, nb, cnt;
    logic        prev, fb;
    logic [14:0] crc;
    nb = v.rtr ? 0 : ((v.dlc > 4'd8) ? 8 : int'(v.dlc));
    u[0] = 1'b0;
    for (int k = 0; k < 11; k++) u[1+k] = v.id[10-k];
    u[12] = v.rtr;
    u[13] = (v.fault == F_IDE);
    u[14] = 1'b0;
    for (int k = 0; k < 4; k++) u[15+k] = v.dlc[3-k];
    for (int k = 0; k < 8*nb; k++) u[19+k] = v.data[63-k];
    nu  = 19 + 8*nb;
    crc = '0;
    for (int k = 0; k < nu; k++) begin
      fb  = u[k] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (fb) crc = crc ^ 15'h4599;
    end
    if (v.fault == F_CRC) u[19] = ~u[19];
    for (int k = 0; k < 15; k++) u[nu+k] = crc[14-k];
    nu = nu + 15;
    slen = 0; cnt = 0; prev = 1'b0; fault_idx = -1;
    for (int k = 0; k < nu; k++) begin
      if (k > 0 && cnt == 5) begin
        if (v.fault == F_STUFF && fault_idx < 0) begin
          stream[slen] = prev;
          fault_idx = slen;
        end else begin
          stream[slen] = ~prev;
        end
        prev = ~prev;
        cnt  = 1;
        slen = slen + 1;
      end
      posmap[k]    = slen;
      stream[slen] = u[k];
      slen = slen + 1;
      if (k == 0 || u[k] != prev) cnt = 1;
      else cnt = cnt + 1;
      prev = u[k];
    end
    data_idx    = posmap[19];
    crc_del_idx = slen;
    for (int k = 0; k < 10; k++) stream[slen+k] = 1'b1;
    if (v.fault == F_EOF4) stream[slen+6] = 1'b0;
    slen = slen + 10;
    for (int k = 0; k < 14; k++) stream[slen+k] = 1'b1;
    slen = slen + 14;
    if (v.fault == F_IDE)  fault_idx = posmap[13];
    if (v.fault == F_CRC)  fault_idx = crc_del_idx;
    if (v.fault == F_EOF4) fault_idx = crc_del_idx + 6;
  endtask

  // Drive stream[0..upto-1]; sample #1 after each edge and log pulses.
  task automatic drive_stream(input int upto);
    valid_cnt = 0; valid_idx = -1; err_cnt = 0; err_idx = -1;
    ack_cnt = 0; ack_idx = -1; err_seen = 3'd0; busy_sof = 1'b0;
    for (int i = 0; i < upto; i++) begin
      rx_bit = stream[i];
      @(posedge can_clk);
      #1;
      if (i == 0) busy_sof = busy;
      if (rx_valid) begin valid_cnt = valid_cnt + 1; valid_idx = i; end
      if (rx_error) begin err_cnt = err_cnt + 1; err_idx = i; err_seen = err_code; end
      if (ack_out)  begin ack_cnt = ack_cnt + 1; ack_idx = i; end
    end
  endtask

  task automatic check_frame(input vec_t v);
    if (v.exp_valid) begin
      last_id = v.id; last_rtr = v.rtr; last_dlc = v.dlc; last_data = v.exp_data;
    end
    chk("valid_count", 64'(valid_cnt), 64'(v.exp_valid));
    if (v.exp_valid) chk("valid_cycle", 64'(valid_idx), 64'(crc_del_idx + 9));
    chk("error_count", 64'(err_cnt), 64'(!v.exp_valid));
    if (!v.exp_valid) begin
      chk("error_cycle", 64'(err_idx), 64'(fault_idx));
      chk("err_code_at_pulse", 64'(err_seen), 64'(v.exp_err));
    end
    chk("ack_count", 64'(ack_cnt), 64'(v.exp_ack));
    if (v.exp_ack) chk("ack_cycle", 64'(ack_idx), 64'(crc_del_idx));
    chk("busy_after_sof", 64'(busy_sof), 64'd1);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("err_code_hold", 64'(err_code), 64'(v.exp_err));
    chk("rx_id", 64'(rx_id), 64'(last_id));
    chk("rx_rtr", 64'(rx_rtr), 64'(last_rtr));
    chk("rx_dlc", 64'(rx_dlc), 64'(last_dlc));
    chk("rx_data", rx_data, last_data);
  endtask

  int pulses;

  initial begin
    vecs[0] = '{11'h123, 1'b0, 4'd1,  64'h8900_0000_0000_0000, F_NONE,  1'b1, 1'b1, 3'd0, 64'h8900_0000_0000_0000};
    vecs[1] = '{11'h000, 1'b0, 4'd2,  64'h0000_0000_0000_0000, F_NONE,  1'b1, 1'b1, 3'd0, 64'h0000_0000_0000_0000};
    vecs[2] = '{11'h123, 1'b0, 4'd1,  64'h8900_0000_0000_0000, F_STUFF, 1'b0, 1'b0, 3'd1, 64'h0};
    vecs[3] = '{11'h123, 1'b0, 4'd1,  64'h8900_0000_0000_0000, F_NONE,  1'b1, 1'b1, 3'd0, 64'h8900_0000_0000_0000};
    vecs[4] = '{11'h123, 1'b0, 4'd1,  64'h8900_0000_0000_0000, F_CRC,   1'b0, 1'b0, 3'd3, 64'h0};
    vecs[5] = '{11'h123, 1'b0, 4'd1,  64'h8900_0000_0000_0000, F_EOF4,  1'b0, 1'b1, 3'd2, 64'h0};
    vecs[6] = '{11'h123, 1'b0, 4'd1,  64'h8900_0000_0000_0000, F_IDE,   1'b0, 1'b0, 3'd4, 64'h0};
    vecs[7] = '{11'h555, 1'b1, 4'd3,  64'hDEAD_BEEF_0000_0000, F_NONE,  1'b1, 1'b1, 3'd0, 64'h0000_0000_0000_0000};
    vecs[8] = '{11'h2A5, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF, F_NONE,  1'b1, 1'b1, 3'd0, 64'h0123_4567_89AB_CDEF};

    last_id = '0; last_rtr = 1'b0; last_dlc = '0; last_data = '0;
    reset  = 1'b1;
    rx_bit = 1'b1;
    repeat (3) @(posedge can_clk);
    #1;
    chk("reset_ctrl_outs", 64'({rx_valid, rx_error, ack_out, busy, rx_rtr}), 64'd0);
    chk("reset_err_code", 64'(err_code), 64'd0);
    chk("reset_rx_id", 64'(rx_id), 64'd0);
    chk("reset_rx_dlc", 64'(rx_dlc), 64'd0);
    chk("reset_rx_data", rx_data, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      rx_bit = 1'b1;
      @(posedge can_clk);
      #1;
    end

    for (int f = 0; f < 9; f++) begin
      cur_frame = f;
      build_frame(vecs[f]);
      drive_stream(slen);
      check_frame(vecs[f]);
    end

    // Reset in the middle of the data field.
    cur_frame = 9;
    build_frame(vecs[0]);
    drive_stream(data_idx + 4);
    chk("pre_reset_pulses", 64'(valid_cnt + err_cnt + ack_cnt), 64'd0);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    reset  = 1'b1;
    rx_bit = 1'b1;
    @(posedge can_clk);
    #1;
    chk("midreset_ctrl_outs", 64'({rx_valid, rx_error, ack_out, busy, rx_rtr}), 64'd0);
    chk("midreset_err_code", 64'(err_code), 64'd0);
    chk("midreset_rx_id", 64'(rx_id), 64'd0);
    chk("midreset_rx_dlc", 64'(rx_dlc), 64'd0);
    chk("midreset_rx_data", rx_data, 64'd0);
    @(posedge can_clk);
    #1;
    reset = 1'b0;
    last_id = '0; last_rtr = 1'b0; last_dlc = '0; last_data = '0;
    pulses = 0;
    for (int i = 0; i < 11; i++) begin
      rx_bit = 1'b1;
      @(posedge can_clk);
      #1;
      if (rx_valid || rx_error || ack_out || busy) pulses = pulses + 1;
    end
    chk("post_reset_quiet", 64'(pulses), 64'd0);
    cur_frame = 10;
    build_frame(vecs[0]);
    drive_stream(slen);
    check_frame(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/can_frame_receiver.md
Name: can_frame_receiver

Overview:
- Standard-format (11-bit ID) CAN 2.0A frame receiver; the receive-side counterpart of the team's CAN transmit node.
- Samples one bus bit per can_clk rising edge and removes stuff bits from SOF through the CRC sequence.
- Parses ID/RTR/DLC/data, checks CRC-15, drives the ACK slot, and presents the completed frame with a one-cycle valid pulse.
- Sits between the bus pins (can_lo_in level) and the node's message-processing logic.

Parameters:
- IDLE_BITS, 11, consecutive recessive bits required to declare bus idle after reset or an error.
- MAX_BYTES, 8, data bytes stored; DLC values above this are clamped.

Ports:
- can_clk  in  1  bit-rate clock; one bus bit per rising edge.
- reset  in  1  synchronous, active-high.
- rx_bit  in  1  sampled bus level; 0 = dominant, 1 = recessive.
- ack_out  out  1  1 = drive dominant during the ACK slot bit.
- rx_valid  out  1  one-cycle pulse when a frame completes error-free.
- rx_id  out  11  received identifier.
- rx_rtr  out  1  received RTR bit.
- rx_dlc  out  4  received DLC, raw and unclamped.
- rx_data  out  64  byte k at [63-8k:56-8k]; unused bytes are 0.
- rx_error  out  1  one-cycle pulse on a detected error.
- err_code  out  3  0 none, 1 stuff, 2 form, 3 crc, 4 ide (extended frame unsupported); holds until the next error or frame.
- busy  out  1  high from SOF until return to IDLE.

Behaviour:
- Reset: all outputs 0; FSM enters WAIT_IDLE; stuff counter, CRC register and bit counter cleared. A reset mid-frame discards the frame with no rx_valid and no rx_error.
- Reset is synchronous, active-high; the clock is can_clk.
- States and transitions:
  - WAIT_IDLE: count consecutive recessive bits; any dominant bit restarts the count. After IDLE_BITS recessive bits → IDLE.
  - IDLE: a dominant bit is SOF → ARB. SOF enters the CRC and the stuff counter.
  - ARB: 11 ID bits, MSB first, then RTR → CTRL.
  - CTRL: IDE, r0, then DLC[3:0].
    - IDE recessive → error 4.
    - r0 is ignored.
    - Next state is DATA if RTR=0 and DLC≠0; otherwise CRC.
  - DATA: 8·min(DLC,8) bits, MSB first → CRC.
  - CRC: 15 bits → CRC_DEL.
  - CRC_DEL: must be recessive, else error 2.
  - ACK_SLOT: any level is accepted.
  - ACK_DEL: must be recessive, else error 2.
  - EOF: 7 bits, all must be recessive, else error 2.
    - On the 7th good EOF bit, rx_valid pulses the next cycle.
    - The rx_* fields update in the same cycle as the pulse and hold until the next valid frame.
  - Then → WAIT_IDLE with count preset to 7 (3-bit intermission + bus idle).
- Destuffing (SOF through last CRC bit):
  - Track run length of identical destuffed-stream bits.
  - After 5 equal bits, the next bit is a stuff bit. If it is opposite, it is discarded and the run restarts at 1 with its value. If it is equal, that is error 1.
  - Stuff bits never enter CRC or field counters.
  - No destuffing from CRC_DEL onward.
- CRC: CRC-15 CAN polynomial 0x4599, init 0.
  - Covers destuffed SOF..last data bit.
  - The received 15-bit sequence is compared against the register at CRC end. A mismatch is error 3, flagged in the CRC_DEL cycle.
- ACK:
  - If the CRC matched and the CRC_DEL bit is recessive, ack_out=1 for exactly the ACK_SLOT bit cycle (registered; asserted on the edge that samples CRC_DEL).
  - ack_out is 0 in all other cycles, including after a CRC error.
- Error: rx_error pulses one cycle, err_code is set, ack_out is forced 0, FSM → WAIT_IDLE with count 0. No rx_valid for that frame. Only the first error of a frame is reported.
- busy is 1 in ARB through EOF inclusive.
- Widths: bit counter 7 bits (max 64 data bits); data shift register 64 bits, zero-filled at SOF.

Decomposition:
- can_pkg contains:
  - state enum localparams;
  - CRC_POLY=15'h4599;
  - error-code constants;
  - field lengths ID_LEN=11, DLC_LEN=4, CRC_LEN=15, EOF_LEN=7.
- Sub-module can_crc15: inputs clk, clear, enable, bit_in; output crc[14:0]; one bit per enabled cycle. Shared with the transmit node.

Test Plan:
- Frame: ID 0x123, RTR 0, DLC 1, data 0x89, stuffed with CRC from the bench model, ACK left recessive → ack_out=1 in the ACK slot only; rx_valid pulses once; rx_id=0x123, rx_dlc=1, rx_data=0x8900_0000_0000_0000, err_code=0.
- Frame: ID 0x000, DLC 2, data 0x00 0x00 (heavy stuffing) → stuff bits removed; rx_data=0x0000_…; valid pulse.
- Same frame as the first with the 6th of a dominant run not inverted (stuff violated) → rx_error pulse, err_code=1, no rx_valid, no ack_out; the next clean frame after 11 recessive bits is received.
- Flip one data bit in the first frame → err_code=3 at CRC_DEL, ack_out stays 0, no rx_valid.
- Dominant bit at EOF position 4 → err_code=2. Separately, IDE recessive → err_code=4.
- Assert reset during DATA of the first frame → outputs 0, no pulses; after reset plus 11 recessive bits, a full frame is received correctly. DLC=15 with RTR=0 → 8 bytes received, rx_dlc=15.
